// File: rtl/vga_text_buffer_pkg.sv
// Shared geometry, character-cell constants, FSM encoding and RAM write payload
// for the VGA text buffer.
package vga_text_buffer_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned CHAR_W    = 8;
  localparam int unsigned CHAR_H    = 8;
  localparam int unsigned COLS      = H_VISIBLE / CHAR_W;
  localparam int unsigned ROWS      = V_VISIBLE / CHAR_H;
  localparam int unsigned CELLS     = COLS * ROWS;
  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned CHAR_BITS = 8;
  localparam int unsigned CNT_W     = 10;

  localparam logic [CHAR_BITS-1:0] FILL_CHAR = 8'h20;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [CHAR_BITS-1:0] data;
  } ram_wr_t;

  // row*80 + col without a multiplier: row*64 + row*16 + col
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] row, input logic [6:0] col);
    return ADDR_W'({row, 6'b0}) + ADDR_W'({row, 4'b0}) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/vga_text_buffer_text_ram.sv
// Simple dual-port character RAM, one write and one registered read port.
// Read and write to the same address in one cycle return the old contents.
module vga_text_buffer_text_ram
  import vga_text_buffer_pkg::*;
(
  input  logic                 clk_25mhz,
  input  logic                 we,
  input  ram_wr_t              wr,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [CHAR_BITS-1:0] rd_data
);

  logic [CHAR_BITS-1:0] mem [CELLS];

  // Non-blocking read and write in one process gives read-first behaviour
  always_ff @(posedge clk_25mhz) begin
    if (we) begin
      mem[wr.addr] <= wr.data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vga_text_buffer.sv
// 80x60 writable character buffer: clear engine, write port, and a two-stage
// pixel-to-character read pipeline feeding the font ROM.
module vga_text_buffer
  import vga_text_buffer_pkg::*;
(
  input  logic                 clk_25mhz,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     h_count,
  input  logic [CNT_W-1:0]     v_count,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [6:0]           wr_col,
  input  logic [5:0]           wr_row,
  input  logic [CHAR_BITS-1:0] wr_char,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 clr_done,
  output logic                 err_oob,
  output logic                 pix_visible,
  output logic [CHAR_BITS-1:0] char_code,
  output logic [2:0]           glyph_row,
  output logic [2:0]           glyph_bit
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              busy_d, wr_ready_d, clr_done_d, err_oob_d;

  logic              accept_c, oob_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic              ram_we_c;
  ram_wr_t           ram_wr_c;

  logic              vis_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [CHAR_BITS-1:0] ram_q;

  logic              vis_s1;
  logic [2:0]        grow_s1, gbit_s1;

  assign accept_c  = wr_valid && wr_ready;
  assign oob_c     = (wr_col >= 7'(COLS)) || (wr_row >= 6'(ROWS));
  assign wr_addr_c = cell_addr({1'b0, wr_row}, wr_col);

  // Next state, clear sweep, write decode and registered-output targets
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_done_d = 1'b0;
    err_oob_d  = 1'b0;
    ram_we_c   = 1'b0;
    ram_wr_c   = '{addr: wr_addr_c, data: wr_char};
    case (state_q)
      ST_CLEAR: begin
        ram_we_c = 1'b1;
        ram_wr_c = '{addr: clr_addr_q, data: FILL_CHAR};
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
          clr_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (accept_c) begin
          ram_we_c  = !oob_c;
          err_oob_d = oob_c;
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    busy_d     = (state_d == ST_CLEAR);
    wr_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy       <= 1'b1;
      wr_ready   <= 1'b0;
      clr_done   <= 1'b0;
      err_oob    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      busy       <= busy_d;
      wr_ready   <= wr_ready_d;
      clr_done   <= clr_done_d;
      err_oob    <= err_oob_d;
    end
  end

  // Stage 1 address is registered inside the RAM; off-screen reads park at 0
  assign vis_c     = (h_count < CNT_W'(H_VISIBLE)) && (v_count < CNT_W'(V_VISIBLE));
  assign rd_addr_c = vis_c ? cell_addr(v_count[9:3], h_count[9:3]) : '0;

  vga_text_buffer_text_ram u_text_ram (
    .clk_25mhz (clk_25mhz),
    .we        (ram_we_c),
    .wr        (ram_wr_c),
    .rd_addr   (rd_addr_c),
    .rd_data   (ram_q)
  );

  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      vis_s1      <= 1'b0;
      grow_s1     <= 3'd0;
      gbit_s1     <= 3'd7;
      pix_visible <= 1'b0;
      char_code   <= FILL_CHAR;
      glyph_row   <= 3'd0;
      glyph_bit   <= 3'd7;
    end else begin
      vis_s1      <= vis_c;
      grow_s1     <= v_count[2:0];
      gbit_s1     <= ~h_count[2:0];
      pix_visible <= vis_s1;
      char_code   <= vis_s1 ? ram_q : FILL_CHAR;
      glyph_row   <= grow_s1;
      glyph_bit   <= gbit_s1;
    end
  end

endmodule

// File: tb/tb_vga_text_buffer.sv
// Directed bench for vga_text_buffer: clear engine timing, write port, pixel
// pipeline vectors and reset/clear corner sequences against a bench-side cell model.
`timescale 1ns/1ps
module tb_vga_text_buffer;

  logic       clk_25mhz = 1'b0;
  logic       rst;
  logic [9:0] h_count, v_count;
  logic       wr_valid, wr_ready;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [7:0] wr_char;
  logic       clr_req, busy, clr_done, err_oob, pix_visible;
  logic [7:0] char_code;
  logic [2:0] glyph_row, glyph_bit;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_mem [4800];

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       vis;
    logic [7:0] code;
    logic [2:0] grow;
    logic [2:0] gbit;
  } vec_t;

  vec_t vecs [16];

  always #20 clk_25mhz = ~clk_25mhz;

  vga_text_buffer dut (
    .clk_25mhz   (clk_25mhz),
    .rst         (rst),
    .h_count     (h_count),
    .v_count     (v_count),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_char     (wr_char),
    .clr_req     (clr_req),
    .busy        (busy),
    .clr_done    (clr_done),
    .err_oob     (err_oob),
    .pix_visible (pix_visible),
    .char_code   (char_code),
    .glyph_row   (glyph_row),
    .glyph_bit   (glyph_bit)
  );

  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_ready"},    32'(wr_ready),    32'd0);
    check({tag, "_busy"},        32'(busy),        32'd1);
    check({tag, "_clr_done"},    32'(clr_done),    32'd0);
    check({tag, "_err_oob"},     32'(err_oob),     32'd0);
    check({tag, "_pix_visible"}, 32'(pix_visible), 32'd0);
    check({tag, "_char_code"},   32'(char_code),   32'h20);
    check({tag, "_glyph_row"},   32'(glyph_row),   32'd0);
    check({tag, "_glyph_bit"},   32'(glyph_bit),   32'd7);
  endtask

  // Counts ticks until busy drops; optionally fires an extra clr_req mid-sweep
  task automatic wait_clear(input int n0, input int req_at, input int exp_len, input string tag);
    int n;
    int pulses;
    n = n0;
    pulses = 0;
    while (busy === 1'b1 && n < 12000) begin
      clr_req = (n == req_at);
      tick();
      clr_req = 1'b0;
      n++;
      if (clr_done === 1'b1) pulses++;
    end
    check({tag, "_clear_len"}, 32'(n), 32'(exp_len));
    check({tag, "_done_at_end"}, 32'(clr_done), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (clr_done === 1'b1) pulses++;
    end
    check({tag, "_done_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic do_write(input logic [6:0] col, input logic [5:0] row, input logic [7:0] ch,
                          input logic exp_oob, input string tag);
    wr_col   = col;
    wr_row   = row;
    wr_char  = ch;
    wr_valid = 1'b1;
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    check({tag, "_oob"}, 32'(err_oob), 32'(exp_oob));
    if (!exp_oob) exp_mem[int'(row) * 80 + int'(col)] = ch;
    tick();
    check({tag, "_oob_pulse_end"}, 32'(err_oob), 32'd0);
  endtask

  // One pixel per cell, pipelined: output after tick j belongs to cell j-1
  task automatic scan(input string tag);
    int errs;
    errs = 0;
    for (int j = 0; j <= 4800; j++) begin
      if (j < 4800) begin
        h_count = 10'((j % 80) * 8 + (j % 8));
        v_count = 10'((j / 80) * 8 + ((j / 8) % 8));
      end
      tick();
      if (j >= 1) begin
        if (char_code !== exp_mem[j-1] || pix_visible !== 1'b1) errs++;
      end
    end
    check({tag, "_scan_cell_errs"}, 32'(errs), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    h_count  = '0;
    v_count  = '0;
    wr_valid = 1'b0;
    wr_col   = '0;
    wr_row   = '0;
    wr_char  = '0;
    clr_req  = 1'b0;
    for (int i = 0; i < 4800; i++) exp_mem[i] = 8'h20;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{10'(240 + i), 10'(208 + i), 1'b1, 8'h50, 3'(i), 3'(7 - i)};
    vecs[8]  = '{10'd239, 10'd208, 1'b1, 8'h20, 3'd0, 3'd0};
    vecs[9]  = '{10'd248, 10'd215, 1'b1, 8'h20, 3'd7, 3'd7};
    vecs[10] = '{10'd240, 10'd207, 1'b1, 8'h20, 3'd7, 3'd7};
    vecs[11] = '{10'd247, 10'd216, 1'b1, 8'h20, 3'd0, 3'd0};
    vecs[12] = '{10'd638, 10'd479, 1'b1, 8'h20, 3'd7, 3'd1};
    vecs[13] = '{10'd639, 10'd479, 1'b1, 8'h20, 3'd7, 3'd0};
    vecs[14] = '{10'd640, 10'd479, 1'b0, 8'h20, 3'd7, 3'd7};
    vecs[15] = '{10'd641, 10'd479, 1'b0, 8'h20, 3'd7, 3'd6};

    repeat (3) tick();
    check_reset("rst0");
    rst = 1'b0;
    wait_clear(0, -1, 4800, "init");
    scan("init");

    do_write(7'd30, 6'd26, 8'h50, 1'b0, "wr_P");
    for (int i = 0; i < 16; i++) begin
      h_count = vecs[i].h;
      v_count = vecs[i].v;
      tick();
      tick();
      check($sformatf("vec%0d_vis", i),  32'(pix_visible), 32'(vecs[i].vis));
      check($sformatf("vec%0d_code", i), 32'(char_code),   32'(vecs[i].code));
      check($sformatf("vec%0d_grow", i), 32'(glyph_row),   32'(vecs[i].grow));
      check($sformatf("vec%0d_gbit", i), 32'(glyph_bit),   32'(vecs[i].gbit));
    end

    do_write(7'd80, 6'd0,  8'h41, 1'b1, "wr_col80");
    do_write(7'd0,  6'd60, 8'h42, 1'b1, "wr_row60");
    do_write(7'd79, 6'd59, 8'h5A, 1'b0, "wr_last");
    do_write(7'd0,  6'd0,  8'h41, 1'b0, "wr_first");
    scan("after_writes");

    // Write and clear in the same cycle; cell (10,5) is pixel (80,40)
    h_count = 10'd80;
    v_count = 10'd40;
    tick();
    tick();
    wr_col   = 7'd10;
    wr_row   = 6'd5;
    wr_char  = 8'h51;
    wr_valid = 1'b1;
    clr_req  = 1'b1;
    check("clr_wr_ready_before", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    clr_req  = 1'b0;
    check("clr_wr_ready_after", 32'(wr_ready), 32'd0);
    check("clr_busy_after", 32'(busy), 32'd1);
    tick();
    check("read_first_old", 32'(char_code), 32'h20);
    tick();
    check("write_before_clear", 32'(char_code), 32'h51);
    for (int i = 0; i < 4800; i++) exp_mem[i] = 8'h20;
    wait_clear(3, 100, 4801, "clr_req");
    scan("after_clr");

    // Reset in the middle of a clear sweep
    h_count = 10'd245;
    v_count = 10'd210;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (2000) tick();
    check("pre_rst_vis", 32'(pix_visible), 32'd1);
    check("pre_rst_gbit", 32'(glyph_bit), 32'd2);
    check("pre_rst_grow", 32'(glyph_row), 32'd2);
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    tick();
    tick();
    check_reset("rst_hold");
    rst = 1'b0;
    wait_clear(0, -1, 4800, "rerun");
    scan("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
